// File: rtl/pipe_hazard_pkg.sv
// Shared encodings for the 5-stage pipeline hazard controller.
// Forwarding select codes, MUL/DIV occupancy states and the forwarding-select helper.
package pipe_hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_e;

  // MEM wins over WB because it holds the younger result; r0 is hardwired to zero.
  function automatic logic [1:0] fwd_sel(
    input logic       mem_regwrite,
    input logic [4:0] mem_dest,
    input logic       wb_regwrite,
    input logic [4:0] wb_dest,
    input logic [4:0] src
  );
    if (mem_regwrite && (mem_dest != 5'd0) && (mem_dest == src)) return FWD_MEM;
    if (wb_regwrite && (wb_dest != 5'd0) && (wb_dest == src))    return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/md_occupancy_fsm.sv
// MUL/DIV occupancy tracker: holds the EX stage for the configured number of cycles
// and pulses md_done in the final cycle.
module md_occupancy_fsm
  import pipe_hazard_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic clk,
  input  logic resetn,
  input  logic ex_md_start,
  input  logic ex_md_is_div,
  output logic md_busy,
  output logic md_done,
  output logic md_stall
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 2);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);

  md_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_md_busy;
  logic             r_md_done;
  logic [CNT_W-1:0] w_load;

  assign w_load = ex_md_is_div ? DIV_LOAD : MUL_LOAD;

  // Occupancy = 1 issue cycle (IDLE) + cnt BUSY cycles + 1 DONE cycle.
  // r_cnt counts the BUSY cycles still to run; a zero load skips BUSY entirely.
  // NOTE: reset is sampled on the clock edge only, so it sits inside the clocked
  // branch with no reset term in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_md_busy <= 1'b0;
      r_md_done <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_md_done <= 1'b0;
          if (ex_md_start) begin
            if (w_load == '0) begin
              r_state   <= DONE;
              r_md_done <= 1'b1;
            end else begin
              r_state   <= BUSY;
              r_cnt     <= w_load;
              r_md_busy <= 1'b1;
            end
          end
        end
        BUSY: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            r_state   <= DONE;
            r_md_busy <= 1'b0;
            r_md_done <= 1'b1;
          end
        end
        DONE: begin
          // The finished instruction is still in EX this cycle; its start is ignored.
          r_state   <= IDLE;
          r_md_done <= 1'b0;
        end
        default: begin
          r_state   <= IDLE;
          r_md_busy <= 1'b0;
          r_md_done <= 1'b0;
        end
      endcase
    end
  end

  assign md_busy  = r_md_busy;
  assign md_done  = r_md_done;
  assign md_stall = ((r_state == IDLE) && ex_md_start) || (r_state == BUSY);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the IF/ID/EX/MEM/WB pipeline: forwarding, load-use
// bubbles, branch flush and MUL/DIV freeze. Optional counters under HAZARD_PERF_EN.
module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       id_branch_taken,
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic [4:0] ex_dest,
  input  logic       ex_regwrite,
  input  logic       ex_is_load,
  input  logic       ex_md_start,
  input  logic       ex_md_is_div,
  input  logic [4:0] mem_dest,
  input  logic       mem_regwrite,
  input  logic [4:0] wb_dest,
  input  logic       wb_regwrite,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel,
  output logic       stall_pc,
  output logic       stall_if_id,
  output logic       stall_id_ex,
  output logic       flush_if_id,
  output logic       flush_id_ex,
  output logic       flush_ex_mem,
  output logic       md_busy,
  output logic       md_done
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_lu_cnt,
  output logic [31:0] perf_md_cnt
`endif
);

  logic w_lu;
  logic w_md_stall;

  assign fwd_a_sel = fwd_sel(mem_regwrite, mem_dest, wb_regwrite, wb_dest, ex_rs);
  assign fwd_b_sel = fwd_sel(mem_regwrite, mem_dest, wb_regwrite, wb_dest, ex_rt);

  assign w_lu = ex_is_load && ex_regwrite && (ex_dest != 5'd0) &&
                ((id_use_rs && (id_rs == ex_dest)) || (id_use_rt && (id_rt == ex_dest)));

  md_occupancy_fsm #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_md_fsm (
    .clk          (clk),
    .resetn       (resetn),
    .ex_md_start  (ex_md_start),
    .ex_md_is_div (ex_md_is_div),
    .md_busy      (md_busy),
    .md_done      (md_done),
    .md_stall     (w_md_stall)
  );

  // A MUL/DIV freeze holds ID/EX in place, so a concurrent load-use must not bubble it.
  assign stall_pc     = w_md_stall || w_lu;
  assign stall_if_id  = w_md_stall || w_lu;
  assign stall_id_ex  = w_md_stall;
  assign flush_id_ex  = w_lu && !w_md_stall;
  assign flush_ex_mem = w_md_stall;
  assign flush_if_id  = id_branch_taken && !w_lu && !w_md_stall;

`ifdef HAZARD_PERF_EN
  logic [31:0] r_perf_lu_cnt;
  logic [31:0] r_perf_md_cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_perf_lu_cnt <= '0;
      r_perf_md_cnt <= '0;
    end else begin
      if (flush_id_ex) r_perf_lu_cnt <= r_perf_lu_cnt + 32'd1;
      if (w_md_stall)  r_perf_md_cnt <= r_perf_md_cnt + 32'd1;
    end
  end

  assign perf_lu_cnt = r_perf_lu_cnt;
  assign perf_md_cnt = r_perf_md_cnt;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central hazard and sequencing controller for the static 5-stage pipeline (IF/ID/EX/MEM/WB).
- Generates operand forwarding selects for EX from the MEM and WB stages.
- Detects load-use hazards and inserts one-cycle bubbles.
- Resolves taken-branch flushes.
- Runs a multi-cycle MUL/DIV occupancy FSM that freezes the front of the pipeline while the HI/LO unit is busy.

Parameters:
- MUL_CYCLES, 4, EX occupancy of MULT/MULTU in cycles (>=2).
- DIV_CYCLES, 32, EX occupancy of DIV/DIVU in cycles (>=2).
- CNT_W, 6, occupancy counter width; must satisfy 2^CNT_W > max(MUL_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  synchronous, active-low reset.
- id_rs  in  5  rs index of the instruction in ID.
- id_rt  in  5  rt index of the instruction in ID.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- id_branch_taken  in  1  branch/jump in ID resolved taken.
- ex_rs  in  5  rs index of the instruction in EX.
- ex_rt  in  5  rt index of the instruction in EX.
- ex_dest  in  5  destination register of EX.
- ex_regwrite  in  1  EX writes the RF.
- ex_is_load  in  1  EX is a load.
- ex_md_start  in  1  EX holds a MUL/DIV that needs issuing.
- ex_md_is_div  in  1  1 = divide, 0 = multiply.
- mem_dest  in  5  MEM destination register.
- mem_regwrite  in  1  MEM writes the RF.
- wb_dest  in  5  WB destination register.
- wb_regwrite  in  1  WB writes the RF.
- fwd_a_sel  out  2  EX operand A source: 0 = ID/EX register, 1 = MEM ALUOut, 2 = WB write data.
- fwd_b_sel  out  2  same encoding, operand B.
- stall_pc  out  1  hold PC.
- stall_if_id  out  1  hold the IF/ID register.
- stall_id_ex  out  1  hold the ID/EX register.
- flush_if_id  out  1  load a bubble into IF/ID.
- flush_id_ex  out  1  load a bubble into ID/EX.
- flush_ex_mem  out  1  load a bubble into EX/MEM.
- md_busy  out  1  MUL/DIV unit occupied (registered).
- md_done  out  1  one-cycle pulse when the result is ready (registered).

Behaviour:
Forwarding (combinational):
- fwd_a_sel = 1 if mem_regwrite & mem_dest!=0 & mem_dest==ex_rs.
- Otherwise fwd_a_sel = 2 if wb_regwrite & wb_dest!=0 & wb_dest==ex_rs.
- Otherwise fwd_a_sel = 0. fwd_b_sel follows the same rule with ex_rt.
- MEM has priority over WB. Register 0 is never forwarded.

Load-use (combinational):
- lu = ex_is_load & ex_regwrite & ex_dest!=0 & ((id_use_rs & id_rs==ex_dest) | (id_use_rt & id_rt==ex_dest)).
- When lu: stall_pc=1, stall_if_id=1, flush_id_ex=1 for exactly one cycle. The load advances to MEM and the hazard clears.

Branch flush:
- flush_if_id = id_branch_taken & ~lu & ~md_stall.
- A branch that is stalled is not flushed until it actually leaves ID.

MUL/DIV FSM (states IDLE, BUSY, DONE):
- IDLE→BUSY on ex_md_start. cnt loads (ex_md_is_div ? DIV_CYCLES : MUL_CYCLES) - 2. md_busy is set next cycle.
- BUSY: cnt decrements each cycle. At cnt==0, BUSY→DONE.
- DONE: md_done=1 and md_busy=0 for one cycle, then →IDLE.
- ex_md_start is ignored in BUSY and DONE. During DONE the same instruction is still in EX and must not re-issue.
- md_stall = (state==IDLE & ex_md_start) | state==BUSY.
- While md_stall: stall_pc=stall_if_id=stall_id_ex=1 and flush_ex_mem=1.
- Total EX occupancy equals the configured cycle count. The instruction leaves EX at the end of the DONE cycle.

Combined stalls:
- md_stall has priority over lu. If both are active, flush_id_ex=0, because ID/EX is held, not bubbled.
- lu is re-evaluated after the stall releases.

Reset:
- state=IDLE, cnt=0, md_busy=0, md_done=0.
- Combinational outputs follow their inputs.
- Reset asserted mid-BUSY aborts the operation immediately. There is no md_done pulse.

Optional Feature:
HAZARD_PERF_EN
- Defined: adds output ports perf_lu_cnt [31:0] and perf_md_cnt [31:0].
  - perf_lu_cnt increments each cycle lu causes a bubble.
  - perf_md_cnt increments each cycle md_stall=1.
  - Both reset to 0, wrap at 2^32, and are registered.
- Undefined: neither the ports nor the counters exist. All other behaviour is identical.

Decomposition:
- Package pipe_hazard_pkg:
  - forwarding select constants FWD_RF=0, FWD_MEM=1, FWD_WB=2.
  - MUL/DIV state encoding IDLE/BUSY/DONE.
- One sub-module, md_occupancy_fsm: state, cnt, md_busy, md_done, md_stall.
- Forwarding and load-use logic stay in the top level.

Test Plan:
- mem_regwrite=1, mem_dest=8, wb_regwrite=1, wb_dest=8, ex_rs=8 -> fwd_a_sel=1. Drop mem_regwrite -> fwd_a_sel=2. Set dest=0 -> 0.
- ex_is_load=1, ex_regwrite=1, ex_dest=5, id_use_rt=1, id_rt=5 -> stall_pc, stall_if_id, flush_id_ex high for exactly one cycle.
- ex_md_start=1, ex_md_is_div=0 with MUL_CYCLES=4 -> md_stall for 3 cycles, md_busy 2 cycles, md_done pulse in cycle 4, stalls low in cycle 4.
- DIV with DIV_CYCLES=32, ex_md_start held high throughout -> exactly one md_done, after 32 cycles. No re-issue in DONE.
- id_branch_taken=1 with lu=1 -> flush_if_id=0. The following cycle, with lu=0 -> flush_if_id=1.
- resetn low at BUSY cycle 10 of a DIV -> next cycle md_busy=0, md_done=0, no stall. With HAZARD_PERF_EN defined, perf_md_cnt reads 0.
